// File: rtl/shiftreg_rw_ctrl.sv
// Upstream controller for the Clock_SR gate: shifts a latched config word out MSB-first
// while capturing the chip's serial readback, then presents it on dout with a valid pulse.
module shiftreg_rw_ctrl #(
  parameter int unsigned WIDTH     = 170,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     din,
  input  logic                 data_in,
  output logic                 sr_start,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 data_out,
  output logic [WIDTH-1:0]     dout,
  output logic                 busy,
  output logic                 valid
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 sr_start_q, sr_start_d;
  logic                 data_out_q, data_out_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    dout_d     = dout_q;
    count_d    = count_q;
    sr_start_d = 1'b0;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;

    case (state_q)
      StIdle: begin
        count_d    = '0;
        data_out_d = 1'b0;
        busy_d     = 1'b0;
        if (start) begin
          shreg_d    = din;
          state_d    = StShift;
          sr_start_d = 1'b1;
          busy_d     = 1'b1;
          data_out_d = din[WIDTH-1];
        end
      end

      StShift: begin
        // Readback enters at the LSB; after WIDTH shifts the first bit received sits at the MSB.
        shreg_d = {shreg_q[WIDTH-2:0], data_in};
        if (count_q == LastCnt) begin
          state_d    = StDone;
          count_d    = '0;
          data_out_d = 1'b0;
        end else begin
          count_d    = count_q + CNT_WIDTH'(1);
          data_out_d = shreg_q[WIDTH-2];
        end
      end

      StDone: begin
        dout_d     = shreg_q;
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        count_d    = '0;
        data_out_d = 1'b0;
        state_d    = StIdle;
      end

      default: begin
        state_d    = StIdle;
        count_d    = '0;
        data_out_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      dout_q     <= '0;
      count_q    <= '0;
      sr_start_q <= 1'b0;
      data_out_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      dout_q     <= dout_d;
      count_q    <= count_d;
      sr_start_q <= sr_start_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign sr_start = sr_start_q;
  assign count    = count_q;
  assign data_out = data_out_q;
  assign dout     = dout_q;
  assign busy     = busy_q;
  assign valid    = valid_q;

endmodule
